load_store_unit: RTL and testbench

//  Downstream of the ALU: takes ALU_Result (effective address) plus rs2 data and performs
//  the data-memory access for LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack memory port.

---
 rtl/load_store_unit_pkg.sv | 38 +++
 rtl/lsu_byte_lane.sv | 51 +++++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states,
// byte-lane masks and the legality rule for an incoming access.
package load_store_unit_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  localparam logic [3:0] LANE_BYTE0   = 4'b0001;
  localparam logic [3:0] LANE_HALF_LO = 4'b0011;
  localparam logic [3:0] LANE_HALF_HI = 4'b1100;
  localparam logic [3:0] LANE_WORD    = 4'b1111;

  // Unsigned sizes exist only for loads; halfwords and words must be naturally aligned.
  function automatic logic lsu_access_ok(input logic rd, input logic wr,
                                         input logic [2:0] f3, input logic [1:0] alo);
    logic ok;
    ok = 1'b0;
    case (f3)
      LSU_B:   ok = !(rd && wr);
      LSU_H:   ok = !(rd && wr) && !alo[0];
      LSU_W:   ok = !(rd && wr) && (alo == 2'b00);
      LSU_BU:  ok = rd && !wr;
      LSU_HU:  ok = rd && !wr && !alo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: load lane extract with sign/zero extension,
// store data replication and byte-enable generation.
module lsu_byte_lane
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_wdata,
  output logic [3:0]  store_be
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte   = rdata[{addr_lo, 3'b000} +: 8];
    rd_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (funct3)
      LSU_B:   load_data = {{24{rd_byte[7]}}, rd_byte};
      LSU_BU:  load_data = {24'd0, rd_byte};
      LSU_H:   load_data = {{16{rd_half[15]}}, rd_half};
      LSU_HU:  load_data = {16'd0, rd_half};
      default: load_data = rdata;
    endcase
  end

  // Size is funct3[1:0], so unsigned load codes get the same lane enables as signed ones.
  always_comb begin
    store_wdata = wdata;
    store_be    = LANE_WORD;
    case (funct3[1:0])
      2'b00: begin
        store_wdata = {4{wdata[7:0]}};
        store_be    = LANE_BYTE0 << addr_lo;
      end
      2'b01: begin
        store_wdata = {2{wdata[15:0]}};
        store_be    = addr_lo[1] ? LANE_HALF_HI : LANE_HALF_LO;
      end
      default: begin
        store_wdata = wdata;
        store_be    = LANE_WORD;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access sequencer: IDLE -> REQ -> DONE over a req/ack port, stalling the
// core until the access finishes; illegal accesses and ack timeouts end with Error_o.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Read_i,
  input  logic        Mem_Write_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic        Stall_o,
  output logic        Done_o,
  output logic        Error_o,
  output logic [31:0] Read_Data_o,
  output logic        Mem_Req_o,
  output logic        Mem_We_o,
  output logic [31:0] Mem_Addr_o,
  output logic [31:0] Mem_Wdata_o,
  output logic [3:0]  Mem_Be_o,
  input  logic        Mem_Ack_i,
  input  logic [31:0] Mem_Rdata_i
);

  lsu_state_t state, state_nxt;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic        load_q;
  logic        err_q;

  logic        access;
  logic        legal;
  logic        timeout;
  logic [2:0]  lane_f3;
  logic [1:0]  lane_alo;
  logic [31:0] lane_load;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;

  assign access  = Mem_Read_i | Mem_Write_i;
  assign legal   = lsu_access_ok(Mem_Read_i, Mem_Write_i, Funct3_i, Address_i[1:0]);
  assign timeout = (wait_cnt == WAIT_WIDTH'(MAX_WAIT - 1));

  // Store steering is needed at the IDLE edge; load extraction uses the latched access in REQ.
  assign lane_f3  = (state == LSU_IDLE) ? Funct3_i : f3_q;
  assign lane_alo = (state == LSU_IDLE) ? Address_i[1:0] : alo_q;

  lsu_byte_lane u_lane (
    .funct3      (lane_f3),
    .addr_lo     (lane_alo),
    .rdata       (Mem_Rdata_i),
    .wdata       (Write_Data_i),
    .load_data   (lane_load),
    .store_wdata (lane_wdata),
    .store_be    (lane_be)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LSU_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    Stall_o   = 1'b0;
    case (state)
      LSU_IDLE: begin
        Stall_o = access & reset;
        if (access) begin
          state_nxt = legal ? LSU_REQ : LSU_DONE;
        end
      end
      LSU_REQ: begin
        Stall_o = 1'b1;
        if (Mem_Ack_i || timeout) begin
          state_nxt = LSU_DONE;
        end
      end
      LSU_DONE: begin
        state_nxt = LSU_IDLE;
      end
      default: begin
        state_nxt = LSU_IDLE;
      end
    endcase
  end

  assign Done_o  = (state == LSU_DONE);
  assign Error_o = (state == LSU_DONE) & err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Mem_Req_o   <= 1'b0;
      Mem_We_o    <= 1'b0;
      Mem_Addr_o  <= '0;
      Mem_Wdata_o <= '0;
      Mem_Be_o    <= '0;
      Read_Data_o <= '0;
      wait_cnt    <= '0;
      f3_q        <= '0;
      alo_q       <= '0;
      load_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          wait_cnt <= '0;
          if (access) begin
            f3_q   <= Funct3_i;
            alo_q  <= Address_i[1:0];
            load_q <= Mem_Read_i;
            if (legal) begin
              err_q       <= 1'b0;
              Mem_Req_o   <= 1'b1;
              Mem_We_o    <= Mem_Write_i;
              Mem_Addr_o  <= {Address_i[31:2], 2'b00};
              Mem_Wdata_o <= lane_wdata;
              Mem_Be_o    <= lane_be;
            end else begin
              err_q <= 1'b1;
              if (Mem_Read_i) begin
                Read_Data_o <= '0;
              end
            end
          end
        end
        LSU_REQ: begin
          if (Mem_Ack_i) begin
            Mem_Req_o <= 1'b0;
            Mem_We_o  <= 1'b0;
            if (load_q) begin
              Read_Data_o <= lane_load;
            end
          end else if (timeout) begin
            Mem_Req_o <= 1'b0;
            Mem_We_o  <= 1'b0;
            err_q     <= 1'b1;
            if (load_q) begin
              Read_Data_o <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases then random accesses, checked
// against an arithmetic model of sizes, lanes and extension.
module tb_load_store_unit;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Mem_Read_i = 1'b0;
  logic        Mem_Write_i = 1'b0;
  logic [2:0]  Funct3_i = 3'b000;
  logic [31:0] Address_i = 32'd0;
  logic [31:0] Write_Data_i = 32'd0;
  logic        Stall_o;
  logic        Done_o;
  logic        Error_o;
  logic [31:0] Read_Data_o;
  logic        Mem_Req_o;
  logic        Mem_We_o;
  logic [31:0] Mem_Addr_o;
  logic [31:0] Mem_Wdata_o;
  logic [3:0]  Mem_Be_o;
  logic        Mem_Ack_i = 1'b0;
  logic [31:0] Mem_Rdata_i = 32'd0;

  load_store_unit #(.MAX_WAIT(MAX_WAIT), .WAIT_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .Mem_Read_i   (Mem_Read_i),
    .Mem_Write_i  (Mem_Write_i),
    .Funct3_i     (Funct3_i),
    .Address_i    (Address_i),
    .Write_Data_i (Write_Data_i),
    .Stall_o      (Stall_o),
    .Done_o       (Done_o),
    .Error_o      (Error_o),
    .Read_Data_o  (Read_Data_o),
    .Mem_Req_o    (Mem_Req_o),
    .Mem_We_o     (Mem_We_o),
    .Mem_Addr_o   (Mem_Addr_o),
    .Mem_Wdata_o  (Mem_Wdata_o),
    .Mem_Be_o     (Mem_Be_o),
    .Mem_Ack_i    (Mem_Ack_i),
    .Mem_Rdata_i  (Mem_Rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [31:0] rd;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_be;
    bit          chk_wd;
  } req_exp_t;

  done_exp_t   done_q[$];
  req_exp_t    req_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rd = 32'd0;
  bit          prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bytes moved by an access; 0 marks a code that is not a valid access of that kind.
  function automatic int acc_bytes(input logic [2:0] f3, input bit wr);
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      3'd4:    return wr ? 0 : 1;
      3'd5:    return wr ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit acc_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] addr);
    int n;
    n = acc_bytes(f3, wr);
    if ((rd && wr) || n == 0) return 1'b0;
    return (addr % n) == 0;
  endfunction

  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int n;
    int off;
    logic [63:0] v;
    logic [63:0] rd64;
    bit          is_signed;
    n = acc_bytes(f3, 1'b0);
    off = int'(addr % 4);
    rd64 = {32'd0, rdata};
    v = (rd64 >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
    is_signed = (f3 < 3'd4);
    if (is_signed && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] rep_wdata(input int n, input logic [31:0] d);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  task automatic do_access(input string name, input bit rd, input bit wr,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int delay);
    bit        ok;
    bit        completes;
    int        n;
    int        exp_stall;
    int        exp_req;
    int        stall_cycles;
    int        req_cycles;
    int        cyc;
    done_exp_t de;
    req_exp_t  re;
    ok = acc_legal(rd, wr, f3, addr);
    n = acc_bytes(f3, wr);
    completes = ok && (delay < MAX_WAIT);
    if (ok) begin
      re.addr   = addr & 32'hFFFF_FFFC;
      re.we     = wr;
      re.be     = 4'(((1 << n) - 1) << int'(addr % 4));
      re.wdata  = rep_wdata(n, wdata);
      re.chk_be = wr || (n == 4);
      re.chk_wd = wr;
      req_q.push_back(re);
    end
    if (rd) model_rd = completes ? ext_load(f3, addr, rdata) : 32'd0;
    de.err = !completes;
    de.rd  = model_rd;
    done_q.push_back(de);
    exp_stall = !ok ? 1 : (completes ? delay + 2 : MAX_WAIT + 1);
    exp_req   = !ok ? 0 : (completes ? delay + 1 : MAX_WAIT);

    @(posedge clk);
    #1;
    Mem_Read_i   = rd;
    Mem_Write_i  = wr;
    Funct3_i     = f3;
    Address_i    = addr;
    Write_Data_i = wdata;
    Mem_Rdata_i  = rdata;
    stall_cycles = 0;
    req_cycles   = 0;
    cyc          = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!Stall_o) break;
      stall_cycles++;
      if (Mem_Req_o) req_cycles++;
      Mem_Ack_i = Mem_Req_o && (req_cycles - 1 == delay);
    end
    chk({name, "_bounded"}, (cyc < 40) ? 32'd1 : 32'd0, 32'd1);
    chk({name, "_stall_cycles"}, stall_cycles, exp_stall);
    chk({name, "_req_cycles"}, req_cycles, exp_req);
    @(posedge clk);
    #1;
    Mem_Ack_i   = 1'b0;
    Mem_Read_i  = 1'b0;
    Mem_Write_i = 1'b0;
  endtask

  // Monitor: every Done pulse and every new memory request is matched against the scoreboard.
  always @(negedge clk) begin
    if (Done_o) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done_o=1, expected no completion pending");
      end else begin
        done_exp_t e;
        e = done_q.pop_front();
        chk("done_error", {31'd0, Error_o}, {31'd0, e.err});
        chk("read_data", Read_Data_o, e.rd);
      end
    end
    if (Mem_Req_o && !prev_req) begin
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got Mem_Req_o=1 at %h, expected no request", Mem_Addr_o);
      end else begin
        req_exp_t r;
        r = req_q.pop_front();
        chk("mem_addr", Mem_Addr_o, r.addr);
        chk("mem_we", {31'd0, Mem_We_o}, {31'd0, r.we});
        if (r.chk_be) chk("mem_be", {28'd0, Mem_Be_o}, {28'd0, r.be});
        if (r.chk_wd) chk("mem_wdata", Mem_Wdata_o, r.wdata);
      end
    end
    prev_req = Mem_Req_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, Mem_Req_o}, 32'd0);
    chk("rst_we", {31'd0, Mem_We_o}, 32'd0);
    chk("rst_done", {31'd0, Done_o}, 32'd0);
    chk("rst_error", {31'd0, Error_o}, 32'd0);
    chk("rst_stall", {31'd0, Stall_o}, 32'd0);
    chk("rst_addr", Mem_Addr_o, 32'd0);
    chk("rst_wdata", Mem_Wdata_o, 32'd0);
    chk("rst_be", {28'd0, Mem_Be_o}, 32'd0);
    chk("rst_read_data", Read_Data_o, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_stall", {31'd0, Stall_o}, 32'd0);

    do_access("lw",   1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    do_access("lb",   1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0);
    do_access("lbu",  1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1);
    do_access("lhu",  1, 0, 3'b101, 32'h102, 32'h0, 32'h80011234, 1);
    do_access("sb",   0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 1);
    do_access("sh",   0, 1, 3'b001, 32'h202, 32'h12345678, 32'h0, 0);
    do_access("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 32'h11111111, 0);
    do_access("rw_both", 1, 1, 3'b010, 32'h100, 32'h0, 32'h11111111, 0);
    do_access("f3_011", 1, 0, 3'b011, 32'h100, 32'h0, 32'h11111111, 0);
    do_access("lh_ok", 1, 0, 3'b001, 32'h106, 32'h0, 32'h7FFF0000, 3);
    do_access("no_ack", 1, 0, 3'b010, 32'h104, 32'h0, 32'h22222222, 99);

    // Reset in the middle of REQ, then an ack that arrives while idle.
    begin
      req_exp_t re;
      re.addr = 32'h300; re.we = 1'b0; re.be = 4'hF; re.wdata = 32'd0;
      re.chk_be = 1'b1; re.chk_wd = 1'b0;
      req_q.push_back(re);
      @(posedge clk);
      #1;
      Mem_Read_i = 1'b1; Funct3_i = 3'b010; Address_i = 32'h300; Mem_Rdata_i = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      chk("mid_req_high", {31'd0, Mem_Req_o}, 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, Mem_Req_o}, 32'd0);
      chk("mid_rst_stall", {31'd0, Stall_o}, 32'd0);
      chk("mid_rst_done", {31'd0, Done_o}, 32'd0);
      chk("mid_rst_rdata", Read_Data_o, 32'd0);
      model_rd = 32'd0;
      Mem_Read_i = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      Mem_Ack_i = 1'b1;
      @(negedge clk);
      Mem_Ack_i = 1'b0;
      chk("late_ack_req", {31'd0, Mem_Req_o}, 32'd0);
      chk("late_ack_done", {31'd0, Done_o}, 32'd0);
      chk("late_ack_stall", {31'd0, Stall_o}, 32'd0);
      @(negedge clk);
      chk("late_ack_done2", {31'd0, Done_o}, 32'd0);
    end
    do_access("lw_after_rst", 1, 0, 3'b010, 32'h400, 32'h0, 32'h0BADF00D, 1);

    for (int i = 0; i < 80; i++) begin
      int          kind;
      bit          rd;
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          dly;
      logic [2:0]  legal_codes [5];
      legal_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      kind = $urandom_range(0, 9);
      rd = (kind < 5) || (kind == 9);
      wr = (kind >= 5);
      if ($urandom_range(0, 3) != 0) f3 = legal_codes[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      dly = ($urandom_range(0, 11) == 0) ? 99 : $urandom_range(0, 4);
      do_access("rand", rd, wr, f3, addr, $urandom, $urandom, dly);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (4) @(negedge clk);
    chk("sb_done_empty", done_q.size(), 32'd0);
    chk("sb_req_empty", req_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
